// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: opcode constants, controller state and
// select encodings, and the instruction classes produced by the decoder.
package mips_pkg;

  localparam int unsigned OP_W = 6;
  localparam int unsigned FN_W = 6;

  localparam logic [OP_W-1:0] OP_RTYPE   = 6'h00;
  localparam logic [OP_W-1:0] OP_ADDI    = 6'h08;
  localparam logic [OP_W-1:0] OP_LW      = 6'h23;
  localparam logic [OP_W-1:0] OP_SW      = 6'h2B;
  localparam logic [OP_W-1:0] OP_BEQ     = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE     = 6'h05;
  localparam logic [OP_W-1:0] OP_J       = 6'h02;
  localparam logic [FN_W-1:0] FN_SYSCALL = 6'h0C;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } ctrl_state_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'd0,
    ALU_SUB   = 2'd1,
    ALU_FUNCT = 2'd2
  } alu_op_t;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JUMP   = 2'd2
  } pc_src_t;

  typedef enum logic [3:0] {
    IC_RTYPE,
    IC_ADDI,
    IC_LOAD,
    IC_STORE,
    IC_BEQ,
    IC_BNE,
    IC_JUMP,
    IC_SYSCALL,
    IC_ILLEGAL
  } inst_class_t;

endpackage

// File: rtl/mips_main_decoder.sv
// Combinational classifier: opcode/funct of the latched instruction to the
// instruction class the control FSM sequences on.
module mips_main_decoder
  import mips_pkg::*;
(
  input  logic [OP_W-1:0] opcode,
  input  logic [FN_W-1:0] funct,
  output inst_class_t     inst_class
);

  always_comb begin
    inst_class = IC_ILLEGAL;
    case (opcode)
      OP_RTYPE: inst_class = (funct == FN_SYSCALL) ? IC_SYSCALL : IC_RTYPE;
      OP_ADDI:  inst_class = IC_ADDI;
      OP_LW:    inst_class = IC_LOAD;
      OP_SW:    inst_class = IC_STORE;
      OP_BEQ:   inst_class = IC_BEQ;
      OP_BNE:   inst_class = IC_BNE;
      OP_J:     inst_class = IC_JUMP;
      default:  inst_class = IC_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/exec/mem/wb and drives
// every datapath enable and select as a combinational function of state.
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned MEM_LAT = 4
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic [OP_W-1:0] opcode,
  input  logic [FN_W-1:0] funct,
  input  logic            alu_zero,
  output logic            ir_write,
  output logic            pc_write,
  output logic [1:0]      pc_src,
  output logic            alu_src_imm,
  output logic [1:0]      alu_op,
  output logic            reg_dst,
  output logic            reg_write,
  output logic            mem_to_reg,
  output logic            mem_read,
  output logic            mem_write_en,
  output logic            halted
);

  localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  ctrl_state_t      state, state_nxt;
  logic [CNT_W-1:0] mem_cnt, mem_cnt_nxt;
  inst_class_t      inst_class;

  mips_main_decoder u_decoder (
    .opcode     (opcode),
    .funct      (funct),
    .inst_class (inst_class)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state   <= S_IDLE;
      mem_cnt <= '0;
    end else begin
      state   <= state_nxt;
      mem_cnt <= mem_cnt_nxt;
    end
  end

  // Next state and Moore-style outputs (branch pc_write also depends on alu_zero).
  always_comb begin
    state_nxt    = state;
    mem_cnt_nxt  = mem_cnt;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = PC_PLUS4;
    alu_src_imm  = 1'b0;
    alu_op       = ALU_ADD;
    reg_dst      = 1'b0;
    reg_write    = 1'b0;
    mem_to_reg   = 1'b0;
    mem_read     = 1'b0;
    mem_write_en = 1'b0;
    halted       = 1'b0;

    case (state)
      S_IDLE: state_nxt = S_FETCH;

      S_FETCH: begin
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        state_nxt = S_DECODE;
      end

      S_DECODE: begin
        if (inst_class == IC_SYSCALL)      state_nxt = S_HALT;
        else if (inst_class == IC_ILLEGAL) state_nxt = S_FETCH;
        else                               state_nxt = S_EXEC;
      end

      S_EXEC: begin
        state_nxt = S_FETCH;
        case (inst_class)
          IC_RTYPE: begin
            alu_op    = ALU_FUNCT;
            state_nxt = S_WB;
          end
          IC_ADDI: begin
            alu_src_imm = 1'b1;
            state_nxt   = S_WB;
          end
          IC_LOAD, IC_STORE: begin
            alu_src_imm = 1'b1;
            mem_cnt_nxt = CNT_W'(MEM_LAT - 1);
            state_nxt   = S_MEM;
          end
          IC_BEQ, IC_BNE: begin
            alu_op   = ALU_SUB;
            pc_src   = PC_BRANCH;
            pc_write = (inst_class == IC_BEQ) ? alu_zero : !alu_zero;
          end
          IC_JUMP: begin
            pc_write = 1'b1;
            pc_src   = PC_JUMP;
          end
          default: state_nxt = S_FETCH;
        endcase
      end

      // Strobe held every MEM cycle; counter counts the remaining cycles.
      S_MEM: begin
        mem_read     = (inst_class == IC_LOAD);
        mem_write_en = (inst_class == IC_STORE);
        if (mem_cnt != '0) mem_cnt_nxt = mem_cnt - CNT_W'(1);
        else               state_nxt   = (inst_class == IC_LOAD) ? S_WB : S_FETCH;
      end

      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = (inst_class == IC_RTYPE);
        mem_to_reg = (inst_class == IC_LOAD);
        state_nxt  = S_FETCH;
      end

      S_HALT: halted = 1'b1;

      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: per-cycle expected output vectors
// are queued as each instruction is driven and popped against two instances.
module tb_mips_multicycle_ctrl;

  typedef logic [12:0] ov_t;

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic [5:0] funct = 6'h00;
  logic       alu_zero = 1'b0;

  logic ir_write4, pc_write4, alu_src_imm4, reg_dst4, reg_write4, mem_to_reg4;
  logic mem_read4, mem_write_en4, halted4;
  logic [1:0] pc_src4, alu_op4;
  logic ir_write1, pc_write1, alu_src_imm1, reg_dst1, reg_write1, mem_to_reg1;
  logic mem_read1, mem_write_en1, halted1;
  logic [1:0] pc_src1, alu_op1;

  ov_t o4, o1;
  ov_t q4[$];
  ov_t q1[$];
  int  errors = 0;
  int  checks = 0;
  string tag = "init";

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.MEM_LAT(4)) dut4 (
    .clk(clk), .rst_b(rst_b), .opcode(opcode), .funct(funct), .alu_zero(alu_zero),
    .ir_write(ir_write4), .pc_write(pc_write4), .pc_src(pc_src4),
    .alu_src_imm(alu_src_imm4), .alu_op(alu_op4), .reg_dst(reg_dst4),
    .reg_write(reg_write4), .mem_to_reg(mem_to_reg4), .mem_read(mem_read4),
    .mem_write_en(mem_write_en4), .halted(halted4)
  );

  mips_multicycle_ctrl #(.MEM_LAT(1)) dut1 (
    .clk(clk), .rst_b(rst_b), .opcode(opcode), .funct(funct), .alu_zero(alu_zero),
    .ir_write(ir_write1), .pc_write(pc_write1), .pc_src(pc_src1),
    .alu_src_imm(alu_src_imm1), .alu_op(alu_op1), .reg_dst(reg_dst1),
    .reg_write(reg_write1), .mem_to_reg(mem_to_reg1), .mem_read(mem_read1),
    .mem_write_en(mem_write_en1), .halted(halted1)
  );

  assign o4 = {halted4, ir_write4, pc_write4, pc_src4, alu_src_imm4, alu_op4,
               reg_dst4, reg_write4, mem_to_reg4, mem_read4, mem_write_en4};
  assign o1 = {halted1, ir_write1, pc_write1, pc_src1, alu_src_imm1, alu_op1,
               reg_dst1, reg_write1, mem_to_reg1, mem_read1, mem_write_en1};

  // Field order: halted ir_write pc_write pc_src alu_src_imm alu_op reg_dst reg_write mem_to_reg mem_read mem_write_en
  function automatic ov_t mk(logic h, logic irw, logic pcw, logic [1:0] pcs, logic imm,
                             logic [1:0] aop, logic rd, logic rw, logic m2r, logic mr, logic mw);
    return {h, irw, pcw, pcs, imm, aop, rd, rw, m2r, mr, mw};
  endfunction

  ov_t V_ZERO, V_FETCH, V_EXEC_R, V_EXEC_I, V_WB_R, V_WB_I, V_WB_LW;
  ov_t V_MEM_R, V_MEM_W, V_BR_T, V_BR_N, V_JMP, V_HALT;

  task automatic push4(input ov_t v, input int n);
    repeat (n) q4.push_back(v);
  endtask

  task automatic push1(input ov_t v, input int n);
    repeat (n) q1.push_back(v);
  endtask

  task automatic check_now();
    ov_t e;
    checks++;
    if (q4.size() == 0) begin
      errors++;
      $display("FAIL %s dut4: observed=%b but no expected value queued", tag, o4);
    end else begin
      e = q4.pop_front();
      assert (o4 === e) else begin
        errors++;
        $error("FAIL %s dut4: observed=%b expected=%b", tag, o4, e);
      end
    end
    if (q1.size() != 0) begin
      checks++;
      e = q1.pop_front();
      assert (o1 === e) else begin
        errors++;
        $error("FAIL %s dut1: observed=%b expected=%b", tag, o1, e);
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) begin
      check_now();
      advance();
    end
  endtask

  task automatic instr(input string t, input logic [5:0] op, input logic [5:0] fn, input logic z);
    tag = t;
    opcode = op;
    funct = fn;
    alu_zero = z;
  endtask

  // Entered at a falling edge; leaves both instances in FETCH at a falling edge.
  task automatic do_reset();
    tag = "reset";
    rst_b = 1'b0;
    #1;
    push4(V_ZERO, 1); push1(V_ZERO, 1);
    check_now();
    @(negedge clk);
    push4(V_ZERO, 1); push1(V_ZERO, 1);
    check_now();
    rst_b = 1'b1;
    tag = "idle";
    push4(V_ZERO, 1); push1(V_ZERO, 1);
    check_now();
    advance();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    V_ZERO   = '0;
    V_FETCH  = mk(1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    V_EXEC_R = mk(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    V_EXEC_I = mk(1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    V_WB_R   = mk(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    V_WB_I   = mk(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    V_WB_LW  = mk(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    V_MEM_R  = mk(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    V_MEM_W  = mk(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    V_BR_T   = mk(1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    V_BR_N   = mk(1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    V_JMP    = mk(1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    V_HALT   = mk(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    do_reset();

    // Instruction stream on the MEM_LAT=4 instance; each starts in FETCH.
    instr("add", 6'h00, 6'h20, 1'b0);
    push4(V_FETCH, 1); push4(V_ZERO, 1); push4(V_EXEC_R, 1); push4(V_WB_R, 1);
    run(4);

    instr("lw", 6'h23, 6'h00, 1'b0);
    push4(V_FETCH, 1); push4(V_ZERO, 1); push4(V_EXEC_I, 1); push4(V_MEM_R, 4); push4(V_WB_LW, 1);
    run(8);

    instr("beq_taken", 6'h04, 6'h00, 1'b1);
    push4(V_FETCH, 1); push4(V_ZERO, 1); push4(V_BR_T, 1);
    run(3);

    instr("beq_not_taken", 6'h04, 6'h00, 1'b0);
    push4(V_FETCH, 1); push4(V_ZERO, 1); push4(V_BR_N, 1);
    run(3);

    instr("bne_zero", 6'h05, 6'h00, 1'b1);
    push4(V_FETCH, 1); push4(V_ZERO, 1); push4(V_BR_N, 1);
    run(3);

    instr("bne_nonzero", 6'h05, 6'h00, 1'b0);
    push4(V_FETCH, 1); push4(V_ZERO, 1); push4(V_BR_T, 1);
    run(3);

    instr("j", 6'h02, 6'h00, 1'b1);
    push4(V_FETCH, 1); push4(V_ZERO, 1); push4(V_JMP, 1);
    run(3);

    instr("addi", 6'h08, 6'h00, 1'b1);
    push4(V_FETCH, 1); push4(V_ZERO, 1); push4(V_EXEC_I, 1); push4(V_WB_I, 1);
    run(4);

    instr("illegal", 6'h3F, 6'h00, 1'b0);
    push4(V_FETCH, 1); push4(V_ZERO, 1);
    run(2);
    tag = "after_illegal";
    push4(V_FETCH, 1);
    check_now();

    // sw on both latencies side by side.
    do_reset();
    instr("sw", 6'h2B, 6'h00, 1'b0);
    push4(V_FETCH, 1); push4(V_ZERO, 1); push4(V_EXEC_I, 1); push4(V_MEM_W, 4); push4(V_FETCH, 1);
    push1(V_FETCH, 1); push1(V_ZERO, 1); push1(V_EXEC_I, 1); push1(V_MEM_W, 1); push1(V_FETCH, 1);
    run(7);
    check_now();

    // Reset pulsed during the second MEM cycle of a store.
    do_reset();
    instr("sw_reset", 6'h2B, 6'h00, 1'b0);
    push4(V_FETCH, 1); push4(V_ZERO, 1); push4(V_EXEC_I, 1); push4(V_MEM_W, 2);
    run(4);
    check_now();
    tag = "sw_reset_async";
    rst_b = 1'b0;
    #1;
    push4(V_ZERO, 1);
    check_now();
    @(negedge clk);
    push4(V_ZERO, 1);
    check_now();
    rst_b = 1'b1;
    tag = "sw_reset_idle";
    push4(V_ZERO, 1);
    check_now();
    advance();
    tag = "sw_reset_fetch";
    push4(V_FETCH, 1);
    check_now();

    // SYSCALL halts; alu_zero toggles while halted and must have no effect.
    instr("syscall", 6'h00, 6'h0C, 1'b0);
    push4(V_FETCH, 1); push4(V_ZERO, 1); push4(V_HALT, 22);
    for (int i = 0; i < 24; i++) begin
      if (i >= 2) alu_zero = ~alu_zero;
      check_now();
      advance();
    end
    tag = "halt_reset";
    rst_b = 1'b0;
    #1;
    push4(V_ZERO, 1);
    check_now();
    @(negedge clk);
    rst_b = 1'b1;
    push4(V_ZERO, 1);
    check_now();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
